l2_mem_responder: RTL and testbench

- Responder (slave) end of the L2 memory bus. Receives the arbitrated single-initiator request stream (address, write data, enable, write enable) and services it from an on-chip word-addressed SRAM array.
- Read and write latencies are configurable.
- Signals completion back to the initiator with read-valid and write-done strobes, plus a busy level.

---
 rtl/l2_mem_responder.sv | 148 ++++++++++++++
 tb/tb_l2_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// Responder end of the L2 memory bus: a single outstanding request is serviced
// from a word-addressed SRAM array after a configurable read/write latency.
module l2_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2,
    parameter int WR_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] l2_mem_access_addr,
    input  logic [31:0] l2_mem_wr_data,
    input  logic        l2_mem_en,
    input  logic        l2_mem_wr_en,
    output logic [31:0] l2_mem_rd_data,
    output logic        l2_mem_rd_valid,
    output logic        l2_mem_wr_done,
    output logic        l2_mem_busy,
    output logic        l2_mem_addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LATENCY - 1);

    // Handshake: a request is taken on any edge where l2_mem_en = 1 and the
    // responder is idle; it completes with exactly one rd_valid or wr_done
    // strobe, and busy stays high from the cycle after accept through the strobe.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          oor_q, oor_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_done_q, wr_done_d;
    logic          busy_q, busy_d;
    logic          addr_err_q, addr_err_d;

    logic [31:0]   mem_array [DEPTH_WORDS];
    logic          mem_we;
    logic          req_oor;
    logic          unused_addr_bits;

    assign req_oor          = |l2_mem_access_addr[31:AW+2];
    assign unused_addr_bits = ^l2_mem_access_addr[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        oor_d     = oor_q;
        is_wr_d   = is_wr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (l2_mem_en) begin
                    idx_d   = l2_mem_access_addr[AW+1:2];
                    oor_d   = req_oor;
                    is_wr_d = l2_mem_wr_en;
                    wdata_d = l2_mem_wr_data;
                    cnt_d   = l2_mem_wr_en ? WR_CNT_INIT : RD_CNT_INIT;
                    state_d = l2_mem_wr_en ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rd_data_d = oor_q ? 32'h0 : mem_array[idx_q];
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_WAIT: begin
                // Out-of-range writes still complete, they just never touch the array.
                if (cnt_q == 4'd0) begin
                    mem_we  = !oor_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        rd_valid_d = (state_d == RESP) && !is_wr_d;
        wr_done_d  = (state_d == RESP) && is_wr_d;
        addr_err_d = (state_d == RESP) && oor_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            oor_q      <= 1'b0;
            is_wr_q    <= 1'b0;
            wdata_q    <= 32'h0;
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            oor_q      <= oor_d;
            is_wr_q    <= is_wr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array has no reset; mem_we is only ever set from WR_WAIT, which reset leaves.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[idx_q] <= wdata_q;
        end
    end

    assign l2_mem_rd_data  = rd_data_q;
    assign l2_mem_rd_valid = rd_valid_q;
    assign l2_mem_wr_done  = wr_done_q;
    assign l2_mem_busy     = busy_q;
    assign l2_mem_addr_err = addr_err_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Randomised scoreboard bench for l2_mem_responder: driver tasks push expected
// completions from a simple memory model, a negedge monitor pops and compares.
module tb_l2_mem_responder;

    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        wr_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_done;
    logic        busy;
    logic        addr_err;

    l2_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .l2_mem_access_addr(addr),
        .l2_mem_wr_data    (wdata),
        .l2_mem_en         (en),
        .l2_mem_wr_en      (wr_en),
        .l2_mem_rd_data    (rd_data),
        .l2_mem_rd_valid   (rd_valid),
        .l2_mem_wr_done    (wr_done),
        .l2_mem_busy       (busy),
        .l2_mem_addr_err   (addr_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    // scoreboard state: entry = {is_write, addr_err, rd_data_expected}
    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_last_rd = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return (a >> 2) >= 32'(DEPTH);
    endfunction

    task automatic push_exp(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit          err;
        int          idx;
        logic [31:0] rd;
        err = is_oor(a);
        idx = int'((a >> 2) % 32'(DEPTH));
        if (wr) begin
            if (!err) model_mem[idx] = d;
            exp_q.push_back({1'b1, err, model_last_rd});
        end else begin
            rd = err ? 32'h0 : model_mem[idx];
            model_last_rd = rd;
            exp_q.push_back({1'b0, err, rd});
        end
    endtask

    // monitor
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst) begin
            if (rd_valid || wr_done) begin
                check("single_strobe", 32'(rd_valid && wr_done), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: actual rd_valid=%0b wr_done=%0b required=none", rd_valid, wr_done);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 32'(wr_done), 32'(e[33]));
                    check("addr_err", 32'(addr_err), 32'(e[32]));
                    check("rd_data", rd_data, e[31:0]);
                end
            end else if (addr_err) begin
                check("addr_err_no_strobe", 32'(addr_err), 32'h0);
            end
        end
    end

    // driver: one request held until its strobe, inputs scrambled while busy
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n      = 0;
        int lat    = -1;
        int busy_n = 0;
        @(negedge clk);
        en = 1'b1; wr_en = wr; addr = a; wdata = d;
        push_exp(wr, a, d);
        while (lat < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (rd_valid || wr_done) begin
                lat = n;
                en = 1'b0; wr_en = 1'b0;
            end else if (busy) begin
                addr = $urandom; wdata = $urandom; wr_en = 1'($urandom_range(0, 1));
            end
        end
        en = 1'b0;
        check(wr ? "wr_latency" : "rd_latency", 32'(lat), 32'((wr ? WR_LAT : RD_LAT) + 1));
        check("busy_cycles", 32'(busy_n), 32'((wr ? WR_LAT : RD_LAT) + 1));
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
        check({tag, "_wr_done"}, 32'(wr_done), 32'h0);
        check({tag, "_addr_err"}, 32'(addr_err), 32'h0);
        check({tag, "_rd_data"}, rd_data, 32'h0);
    endtask

    initial begin
        int strobes;
        int prev;
        int n;
        logic [31:0] a;

        rst = 1'b1; en = 1'b0; wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // directed
        do_req(1'b1, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 32'h0);
        check("rd_data_hold", rd_data, 32'hDEADBEEF);
        do_req(1'b1, 32'h0, 32'h1111_0000);
        do_req(1'b1, 32'h1000, 32'h1234);
        do_req(1'b0, 32'h0, 32'h0);
        do_req(1'b0, 32'h1000, 32'h0);

        // continuous read request at 0x4 with inputs scrambled while busy
        do_req(1'b1, 32'h4, 32'hC0DE_0004);
        repeat (4) push_exp(1'b0, 32'h4, 32'h0);
        @(negedge clk);
        en = 1'b1; wr_en = 1'b0; addr = 32'h4;
        strobes = 0; prev = -1; n = 0;
        while (strobes < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (rd_valid) begin
                strobes++;
                if (prev >= 0) check("hold_period", 32'(cyc - prev), 32'(RD_LAT + 2));
                prev = cyc;
                addr = 32'h4; wr_en = 1'b0;
                if (strobes == 4) en = 1'b0;
            end else if (busy) begin
                addr = $urandom; wdata = $urandom; wr_en = 1'($urandom_range(0, 1));
            end
        end
        en = 1'b0;
        check("hold_strobes", 32'(strobes), 32'd4);
        @(negedge clk);

        // reset while a write is waiting to commit
        do_req(1'b1, 32'h8, 32'h5A5A_0008);
        @(negedge clk);
        en = 1'b1; wr_en = 1'b1; addr = 32'h8; wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        en = 1'b0; wr_en = 1'b0;
        check("mid_reset_no_done", 32'(wr_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_last_rd = 32'h0;
        do_req(1'b0, 32'h8, 32'h0);

        // write then read back-to-back with en held high
        @(negedge clk);
        en = 1'b1; wr_en = 1'b1; addr = 32'h20; wdata = 32'h1;
        push_exp(1'b1, 32'h20, 32'h1);
        push_exp(1'b0, 32'h20, 32'h0);
        n = 0;
        while (!wr_done && n < 20) begin @(negedge clk); n++; end
        check("b2b_wr_seen", 32'(wr_done), 32'h1);
        wr_en = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_valid && n < 20);
        check("b2b_rd_seen", 32'(rd_valid), 32'h1);
        en = 1'b0;
        @(negedge clk);

        // random traffic over a small word pool plus out-of-range addresses
        for (int i = 0; i < 32; i++) do_req(1'b1, 32'(i * 4), $urandom);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 2) a = $urandom | 32'h1000;
            else a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        check("queue_drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
